// File: rtl/alu_sequencer.sv
// alu_sequencer: issues 12-bit instructions to a combinational 4-bit ALU and writes its results back
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake; instr = {opcode, rd, rs1, rs2, 2'b00}, LDI imm = instr[5:2]
//   alu_opcode/op1/op2       registered operands presented to the ALU during EXEC
//   alu_dout/alu_eflags      ALU result and flags {zero, neg, overflow, carry}, captured at writeback
//   flags_q                  architectural flags register
//   done                     one-cycle pulse after writeback
//   err                      sticky illegal-opcode flag
//   rd_sel/rd_data           combinational debug read port into the register file
//   retired                  wrapping count of retired legal instructions
module alu_sequencer #(
   parameter int DW    = 4,
   parameter int NREG  = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [11:0]      instr,
   output logic             instr_ready,
   output logic [3:0]       alu_opcode,
   output logic [DW-1:0]    alu_op1,
   output logic [DW-1:0]    alu_op2,
   input  logic [DW-1:0]    alu_dout,
   input  logic [3:0]       alu_eflags,
   output logic [3:0]       flags_q,
   output logic             done,
   output logic             err,
   input  logic [1:0]       rd_sel,
   output logic [DW-1:0]    rd_data,
   output logic [CNT_W-1:0] retired
);
   typedef enum logic {IDLE, EXEC} state_t;
   state_t state_q, state_d;
   logic ready_q, ready_d, done_q, done_d, err_q, err_d;
   logic [11:2] instr_q, instr_d;
   logic [3:0] opc_q, opc_d, flags_d, op;
   logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [1:0] rd;
   logic unused;
   // the two low instruction bits carry no information
   assign unused = ^instr[1:0];
   assign op = instr_q[11:8];
   assign rd = instr_q[7:6];
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      regs_d  = regs_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ret_d   = ret_q;
      if (state_q == EXEC) begin
         state_d = IDLE;
         opc_d   = '0;
         op1_d   = '0;
         op2_d   = '0;
         done_d  = 1'b1;
         if (op inside {4'd1, 4'd2, 4'd4, 4'd5}) regs_d[rd] = alu_dout;
         if (op == 4'd6) regs_d[rd] = DW'(instr_q[5:2]);
         if (op inside {4'd1, 4'd2, 4'd3}) flags_d = alu_eflags;
         err_d = err_q | (op > 4'd6);
         ret_d = (op > 4'd6) ? ret_q : ret_q + 1'b1;
      end else if (instr_valid && ready_q) begin
         state_d = EXEC;
         instr_d = instr[11:2];
         // only real ALU operations reach the ALU; LDI, NOP and illegal codes present 0
         opc_d   = (instr[11:8] >= 4'd1 && instr[11:8] <= 4'd5) ? instr[11:8] : 4'd0;
         op1_d   = regs_q[instr[5:4]];
         op2_d   = regs_q[instr[3:2]];
      end
      ready_d = (state_d == IDLE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         regs_q  <= '{default: '0};
         flags_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         regs_q  <= regs_d;
         flags_q <= flags_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ret_q   <= ret_d;
      end
   end
   assign instr_ready = ready_q;
   assign alu_opcode  = opc_q;
   assign alu_op1     = op1_q;
   assign alu_op2     = op2_q;
   assign done        = done_q;
   assign err         = err_q;
   assign retired     = ret_q;
   assign rd_data     = regs_q[rd_sel];
endmodule
